// File: rtl/pulse_meas_pkg.sv
// Shared types and constants for the pulse measurement sequencer.
package pulse_meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_RISE,
        HIGH,
        LOW,
        DONE
    } meas_state_e;

    localparam int CNT_W_DEF = 32;
    localparam int TO_W_DEF  = 32;

    localparam logic [CNT_W_DEF-1:0] SAT_MAX = '1;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous input with rise/fall detection
// on the synchronised level.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = s_o & ~s_d_q;
    assign fall_o = ~s_o & s_d_q;

endmodule

// File: rtl/pulse_meas_ctrl.sv
// Measures the high time and rise-to-rise period of one pulse on a selected
// channel, with timeout and saturation, and holds the result for a handshake.
module pulse_meas_ctrl
    import pulse_meas_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TO_W        = TO_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             chan_sel_i,
    input  logic             signal_1_i,
    input  logic             signal_2_i,
    input  logic [TO_W-1:0]  timeout_cycles_i,
    output logic             busy_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [CNT_W-1:0] high_count_o,
    output logic [CNT_W-1:0] period_count_o,
    output logic             timeout_flag_o,
    output logic             overflow_o,
    output logic             chan_out_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    meas_state_e      state_q, state_d;
    logic             chan_q, chan_d;
    logic [TO_W-1:0]  to_lim_q, to_lim_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             ovf_q, ovf_d;
    logic             tof_q, tof_d;
    logic             busy_q, busy_d;

    logic sel, raw, s, rise, fall, timed_out;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CNT_W'(1);
    endfunction

    // While idle the synchroniser tracks the requested channel so it already
    // holds that pin's level when a measurement is accepted.
    assign sel = (state_q == IDLE) ? chan_sel_i : chan_q;
    assign raw = sel ? signal_2_i : signal_1_i;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (sys_clk_i),
        .rst_i  (reset_i),
        .d_i    (raw),
        .s_o    (s),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign timed_out = (to_lim_q != '0) && (to_cnt_q == to_lim_q);

    always_ff @(posedge sys_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            chan_q   <= 1'b0;
            to_lim_q <= '0;
            to_cnt_q <= '0;
            high_q   <= '0;
            per_q    <= '0;
            ovf_q    <= 1'b0;
            tof_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            to_lim_q <= to_lim_d;
            to_cnt_q <= to_cnt_d;
            high_q   <= high_d;
            per_q    <= per_d;
            ovf_q    <= ovf_d;
            tof_q    <= tof_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        to_lim_d = to_lim_q;
        to_cnt_d = to_cnt_q;
        high_d   = high_q;
        per_d    = per_q;
        ovf_d    = ovf_q;
        tof_d    = tof_q;
        busy_d   = busy_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    chan_d   = chan_sel_i;
                    to_lim_d = timeout_cycles_i;
                    to_cnt_d = '0;
                    high_d   = '0;
                    per_d    = '0;
                    ovf_d    = 1'b0;
                    tof_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ARM;
                end
            end
            ARM, WAIT_RISE, HIGH, LOW: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                // Timeout wins over any edge seen in the same cycle.
                if (timed_out) begin
                    tof_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    case (state_q)
                        ARM: begin
                            if (!s) state_d = WAIT_RISE;
                        end
                        WAIT_RISE: begin
                            if (rise) begin
                                high_d  = CNT_W'(1);
                                per_d   = CNT_W'(1);
                                state_d = HIGH;
                            end
                        end
                        HIGH: begin
                            if (fall) begin
                                per_d   = sat_inc(per_q);
                                state_d = LOW;
                            end else if (s) begin
                                high_d = sat_inc(high_q);
                                per_d  = sat_inc(per_q);
                            end
                        end
                        default: begin
                            if (rise) begin
                                state_d = DONE;
                            end else begin
                                per_d = sat_inc(per_q);
                            end
                        end
                    endcase
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Sticky until the next accepted start clears the counts to zero.
        if ((high_d == CntMax) || (per_d == CntMax)) begin
            ovf_d = 1'b1;
        end
    end

    assign busy_o         = busy_q;
    assign result_valid_o = (state_q == DONE);
    assign high_count_o   = high_q;
    assign period_count_o = per_q;
    assign timeout_flag_o = tof_q;
    assign overflow_o     = ovf_q;
    assign chan_out_o     = chan_q;

endmodule

// File: tb/tb_pulse_meas_ctrl.sv
// Scoreboard bench for pulse_meas_ctrl: a 32-bit instance plus a CNT_W=4
// instance for saturation.
module tb_pulse_meas_ctrl;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        start;
    logic        chan_sel;
    logic        signal_1;
    logic        signal_2;
    logic [31:0] timeout_cycles;
    logic        result_ready;
    logic        busy;
    logic        result_valid;
    logic [31:0] high_count;
    logic [31:0] period_count;
    logic        timeout_flag;
    logic        overflow;
    logic        chan_out;

    logic        start4;
    logic        busy4;
    logic        rv4;
    logic [3:0]  hc4;
    logic [3:0]  pc4;
    logic        tf4;
    logic        ov4;
    logic        co4;

    typedef struct {
        logic [31:0] high;
        logic [31:0] per;
        logic        tof;
        logic        ovf;
        logic        chan;
    } exp_t;

    exp_t sbMain[$];
    exp_t sb4[$];
    exp_t eMain;
    exp_t e4;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    pulse_meas_ctrl u_dut (
        .sys_clk_i        (sys_clk),
        .reset_i          (reset),
        .start_i          (start),
        .chan_sel_i       (chan_sel),
        .signal_1_i       (signal_1),
        .signal_2_i       (signal_2),
        .timeout_cycles_i (timeout_cycles),
        .busy_o           (busy),
        .result_valid_o   (result_valid),
        .result_ready_i   (result_ready),
        .high_count_o     (high_count),
        .period_count_o   (period_count),
        .timeout_flag_o   (timeout_flag),
        .overflow_o       (overflow),
        .chan_out_o       (chan_out)
    );

    pulse_meas_ctrl #(.CNT_W(4)) u_dut4 (
        .sys_clk_i        (sys_clk),
        .reset_i          (reset),
        .start_i          (start4),
        .chan_sel_i       (1'b0),
        .signal_1_i       (signal_1),
        .signal_2_i       (signal_2),
        .timeout_cycles_i (32'd0),
        .busy_o           (busy4),
        .result_valid_o   (rv4),
        .result_ready_i   (1'b1),
        .high_count_o     (hc4),
        .period_count_o   (pc4),
        .timeout_flag_o   (tf4),
        .overflow_o       (ov4),
        .chan_out_o       (co4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
        checks++;
        if (obs !== expVal) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expVal);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic applyStimulus(input int ch, input logic lvl, input int n);
        if (ch == 0) signal_1 = lvl;
        else         signal_2 = lvl;
        tick(n);
    endtask

    task automatic startMeas(input logic ch, input logic [31:0] to);
        chan_sel       = ch;
        timeout_cycles = to;
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pushMain(input int h, input int p, input logic tof, input logic ovf, input logic ch);
        exp_t e;
        e.high = h; e.per = p; e.tof = tof; e.ovf = ovf; e.chan = ch;
        sbMain.push_back(e);
    endtask

    task automatic waitNotBusy(input int maxCycles);
        int k = 0;
        while (busy && k < maxCycles) begin
            @(negedge sys_clk);
            k++;
        end
        if (busy) checkOutput("busyTimeout", 32'd1, 32'd0);
        tick(1);
    endtask

    // Main instance: compare each result as it is handed off.
    always @(negedge sys_clk) begin
        if (!reset && result_valid && result_ready) begin
            if (sbMain.size() == 0) begin
                checkOutput("mainUnexpected", 32'd1, 32'd0);
            end else begin
                eMain = sbMain.pop_front();
                checkOutput("mainHigh", high_count, eMain.high);
                checkOutput("mainPeriod", period_count, eMain.per);
                checkOutput("mainTimeout", {31'd0, timeout_flag}, {31'd0, eMain.tof});
                checkOutput("mainOverflow", {31'd0, overflow}, {31'd0, eMain.ovf});
                checkOutput("mainChan", {31'd0, chan_out}, {31'd0, eMain.chan});
            end
        end
    end

    always @(negedge sys_clk) begin
        if (!reset && rv4) begin
            if (sb4.size() == 0) begin
                checkOutput("narrowUnexpected", 32'd1, 32'd0);
            end else begin
                e4 = sb4.pop_front();
                checkOutput("narrowHigh", {28'd0, hc4}, e4.high);
                checkOutput("narrowPeriod", {28'd0, pc4}, e4.per);
                checkOutput("narrowTimeout", {31'd0, tf4}, {31'd0, e4.tof});
                checkOutput("narrowOverflow", {31'd0, ov4}, {31'd0, e4.ovf});
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        exp_t e;

        reset = 1'b1; start = 1'b0; start4 = 1'b0; chan_sel = 1'b0;
        signal_1 = 1'b0; signal_2 = 1'b0; timeout_cycles = '0; result_ready = 1'b1;
        tick(3);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstValid", {31'd0, result_valid}, 32'd0);
        checkOutput("rstHigh", high_count, 32'd0);
        checkOutput("rstPeriod", period_count, 32'd0);
        checkOutput("rstFlags", {29'd0, timeout_flag, overflow, chan_out}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Channel 0, 10 high / 15 low, repeating.
        $display("[TB] basic measurement on signal_1");
        pushMain(10, 25, 1'b0, 1'b0, 1'b0);
        startMeas(1'b0, 32'd0);
        #3 checkOutput("busyAfterStart", {31'd0, busy}, 32'd1);
        applyStimulus(0, 1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b1, 10);
            applyStimulus(0, 1'b0, 15);
        end
        waitNotBusy(100);
        checkOutput("validClearedT1", {31'd0, result_valid}, 32'd0);

        // Pulse already in progress at start is skipped.
        $display("[TB] partial pulse ignored");
        signal_1 = 1'b1;
        pushMain(4, 10, 1'b0, 1'b0, 1'b0);
        startMeas(1'b0, 32'd0);
        applyStimulus(0, 1'b1, 8);
        applyStimulus(0, 1'b0, 6);
        applyStimulus(0, 1'b1, 4);
        applyStimulus(0, 1'b0, 6);
        applyStimulus(0, 1'b1, 4);
        applyStimulus(0, 1'b0, 5);
        waitNotBusy(100);

        // Channel 1 stuck low with timeout 50 while channel 0 toggles.
        $display("[TB] timeout on signal_2");
        signal_2 = 1'b0;
        pushMain(0, 0, 1'b1, 1'b0, 1'b1);
        startMeas(1'b1, 32'd50);
        n = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    applyStimulus(0, 1'b1, 3);
                    applyStimulus(0, 1'b0, 3);
                end
            end
            begin
                while (!result_valid && n < 200) begin
                    @(posedge sys_clk);
                    #1;
                    n++;
                end
            end
        join
        checkOutput("timeoutLatency", n, 32'd51);
        waitNotBusy(100);

        // Narrow instance saturates.
        $display("[TB] saturation with CNT_W=4");
        signal_1 = 1'b0;
        e.high = 15; e.per = 15; e.tof = 1'b0; e.ovf = 1'b1; e.chan = 1'b0;
        sb4.push_back(e);
        tick(4);
        start4 = 1'b1;
        tick(1);
        start4 = 1'b0;
        applyStimulus(0, 1'b1, 20);
        applyStimulus(0, 1'b0, 5);
        applyStimulus(0, 1'b1, 3);
        applyStimulus(0, 1'b0, 3);
        n = 0;
        while (busy4 && n < 100) begin
            tick(1);
            n++;
        end
        checkOutput("narrowBusyDone", {31'd0, busy4}, 32'd0);
        checkOutput("mainStayedIdle", {31'd0, busy}, 32'd0);

        // Result held while the consumer stalls; extra start ignored.
        $display("[TB] backpressure in DONE");
        result_ready = 1'b0;
        signal_1 = 1'b0;
        pushMain(3, 8, 1'b0, 1'b0, 1'b0);
        startMeas(1'b0, 32'd0);
        applyStimulus(0, 1'b1, 3);
        applyStimulus(0, 1'b0, 5);
        applyStimulus(0, 1'b1, 2);
        applyStimulus(0, 1'b0, 2);
        n = 0;
        while (!result_valid && n < 100) begin
            tick(1);
            n++;
        end
        checkOutput("heldValidSeen", {31'd0, result_valid}, 32'd1);
        for (int i = 0; i < 30; i++) begin
            start = (i == 10);
            if (i == 10) chan_sel = 1'b1;
            #3;
            if (i % 5 == 0) begin
                checkOutput("heldHigh", high_count, 32'd3);
                checkOutput("heldPeriod", period_count, 32'd8);
                checkOutput("heldBusy", {31'd0, busy}, 32'd1);
                checkOutput("heldValid", {31'd0, result_valid}, 32'd1);
            end
            tick(1);
        end
        start = 1'b0;
        checkOutput("heldChan", {31'd0, chan_out}, 32'd0);
        result_ready = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        #3;
        checkOutput("busyAfterAck", {31'd0, busy}, 32'd0);
        checkOutput("validAfterAck", {31'd0, result_valid}, 32'd0);
        tick(6);
        checkOutput("startAtAckIgnored", {31'd0, busy}, 32'd0);

        // Reset during HIGH on channel 1, then a fresh measurement.
        $display("[TB] reset during HIGH");
        signal_2 = 1'b0;
        startMeas(1'b1, 32'd0);
        applyStimulus(1, 1'b1, 8);
        checkOutput("inHighBeforeReset", {31'd0, (high_count != 0)}, 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("asyncRstHigh", high_count, 32'd0);
        checkOutput("asyncRstPeriod", period_count, 32'd0);
        checkOutput("asyncRstFlags", {28'd0, result_valid, timeout_flag, overflow, chan_out}, 32'd0);
        tick(2);
        reset = 1'b0;
        signal_2 = 1'b0;
        tick(3);
        pushMain(6, 9, 1'b0, 1'b0, 1'b1);
        startMeas(1'b1, 32'd0);
        applyStimulus(1, 1'b1, 6);
        applyStimulus(1, 1'b0, 3);
        applyStimulus(1, 1'b1, 3);
        applyStimulus(1, 1'b0, 3);
        waitNotBusy(100);

        tick(2);
        checkOutput("sbMainEmpty", sbMain.size(), 32'd0);
        checkOutput("sbNarrowEmpty", sb4.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_meas_ctrl.md
Name: pulse_meas_ctrl

Overview:
- Sequencer for the pulse-width counting datapath. On command it selects one of the two raw inputs (signal_1 or signal_2) and synchronises it to sys_clk.
- It then measures one complete pulse: high time and full period (rise to next rise), both in sys_clk cycles, with timeout and saturation protection.
- Results are held until the downstream register/bus interface consumes them through a valid/ready handshake.

Parameters:
CNT_W, 32, width of the high_count and period_count result counters
TO_W, 32, width of the timeout_cycles input and the internal timeout counter
SYNC_STAGES, 2, number of flops in the input synchroniser (minimum 2)

Ports:
sys_clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a measurement; accepted only in IDLE
chan_sel  input  1  0 selects signal_1, 1 selects signal_2; sampled when start is accepted
signal_1  input  1  asynchronous measured input, channel 0
signal_2  input  1  asynchronous measured input, channel 1
timeout_cycles  input  TO_W  measurement time limit, sampled with start; 0 disables the timeout
busy  output  1  high from start acceptance until the result handshake completes
result_valid  output  1  result fields are stable and valid
result_ready  input  1  consumer accepts the result when high together with result_valid
high_count  output  CNT_W  synchronised high-phase length in cycles
period_count  output  CNT_W  rise-to-rise length in cycles
timeout_flag  output  1  measurement ended by timeout; counts are partial
overflow  output  1  a counter saturated at all-ones during this measurement
chan_out  output  1  the channel that was measured

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and the synchroniser flops are 0. Reset mid-measurement aborts immediately with no result.
- Synchroniser and edge detect:
  - The selected input passes through SYNC_STAGES flops; s is the last stage and s_d is s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - The mux selection is latched at start, so changing chan_sel while busy has no effect.
- FSM states and transitions:
  - IDLE: start=1 latches chan and timeout_cycles, clears counts and flags, sets busy=1 next cycle, and goes to ARM. start is ignored in every other state.
  - ARM: waits for s=0, so a pulse already in progress is never measured, then goes to WAIT_RISE.
  - WAIT_RISE: on rise, set high_cnt=1 and per_cnt=1, then go to HIGH.
  - HIGH: each cycle with s=1, increment high_cnt and per_cnt. On fall, increment per_cnt only and go to LOW.
  - LOW: each cycle with s=0, increment per_cnt. On rise, go to DONE with per_cnt unchanged; period excludes the rising cycle.
  - DONE: result_valid=1 and outputs are held stable. On result_valid & result_ready, clear result_valid and busy the next cycle and return to IDLE.
- Width rules: high_cnt and per_cnt saturate at 2^CNT_W-1. Reaching saturation sets overflow, which is sticky until the next start. The counters never wrap.
- Timeout:
  - A TO_W counter starts at 0 on leaving IDLE and increments every cycle in ARM, WAIT_RISE, HIGH and LOW.
  - When it equals timeout_cycles (non-zero), go to DONE with timeout_flag=1 and the partial counts as they stand.
  - Timeout has priority over an edge in the same cycle.
- Latency: an input edge on a pin reaches the FSM SYNC_STAGES+1 cycles later. result_valid rises on the cycle after the terminating rise is detected.
- Start asserted in the same cycle as a DONE handshake is ignored; the FSM is not in IDLE that cycle.

Decomposition:
- Shared package pulse_meas_pkg:
  - FSM state enum: IDLE, ARM, WAIT_RISE, HIGH, LOW, DONE.
  - CNT_W and TO_W defaults.
  - Saturating-max constant.
- One sub-module, sync_edge_det: parameterised SYNC_STAGES synchroniser producing s, rise and fall. The top instantiates it after the channel mux.

Test Plan:
- chan_sel=0, timeout 0, signal_1 high for 10 cycles then low for 15, repeating -> result_valid with high_count=10, period_count=25, chan_out=0, both flags 0.
- signal_1 already high when start is accepted -> first partial pulse ignored; a following 4-high/6-low pulse reports 4/10.
- chan_sel=1, timeout_cycles=50, signal_2 held low -> DONE after 50 cycles, timeout_flag=1, high_count=0, period_count=0.
- CNT_W=4 override, pulse high for 20 cycles -> high_count=15, overflow=1, measurement still completes.
- result_ready held low for 30 cycles in DONE -> outputs stable, busy=1, a second start is ignored; ready=1 returns busy to 0 the next cycle.
- reset asserted during HIGH -> all outputs 0 asynchronously; a fresh start afterwards measures normally.
